// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up, cancel and direct HI/LO writes.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    input  logic             hiwe,
    input  logic             lowe,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             prodv,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           st, st_n;
    logic [CNTW-1:0]  cnt, cnt_n;
    logic             op_r, op_n;
    logic             nega, nega_n, negb, negb_n;
    logic [WIDTH-1:0] acc, acc_n, q, q_n, b, b_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             prodv_n, divzero_n, busy_n;

    logic [WIDTH-1:0]   absa, absb, quo, rem;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH-1:0] prod;

    // next-state and datapath: acc/q form the product pair or the remainder/quotient pair
    always_comb begin
        st_n      = st;
        cnt_n     = cnt;
        op_n      = op_r;
        nega_n    = nega;
        negb_n    = negb;
        acc_n     = acc;
        q_n       = q;
        b_n       = b;
        hi_n      = hi;
        lo_n      = lo;
        divzero_n = divzero;
        prodv_n   = 1'b0;

        absa  = (sgn && srca[WIDTH-1]) ? -srca : srca;
        absb  = (sgn && srcb[WIDTH-1]) ? -srcb : srcb;
        sum   = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
        trial = {acc, q[WIDTH-1]} - {1'b0, b};
        prod  = (nega ^ negb) ? -{acc, q} : {acc, q};
        quo   = (nega ^ negb) ? -q : q;
        rem   = nega ? -acc : acc;

        case (st)
            IDLE: begin
                if (start && !cancel) begin
                    st_n   = RUN;
                    cnt_n  = CNTW'(WIDTH - 1);
                    op_n   = op;
                    nega_n = sgn & srca[WIDTH-1];
                    negb_n = sgn & srcb[WIDTH-1];
                    acc_n  = '0;
                    q_n    = absa;
                    b_n    = absb;
                end else begin
                    if (hiwe) hi_n = wdata;
                    if (lowe) lo_n = wdata;
                end
            end
            RUN: begin
                if (cancel) begin
                    st_n = IDLE;
                end else begin
                    if (!op_r) begin
                        acc_n = sum[WIDTH:1];
                        q_n   = {sum[0], q[WIDTH-1:1]};
                    end else if (!trial[WIDTH]) begin
                        acc_n = trial[WIDTH-1:0];
                        q_n   = {q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_n = {acc[WIDTH-2:0], q[WIDTH-1]};
                        q_n   = {q[WIDTH-2:0], 1'b0};
                    end
                    cnt_n = cnt - CNTW'(1);
                    if (cnt == '0) st_n = FIX;
                end
            end
            FIX: begin
                st_n = IDLE;
                if (!cancel) begin
                    prodv_n = 1'b1;
                    if (!op_r) begin
                        {hi_n, lo_n} = prod;
                        divzero_n    = 1'b0;
                    end else if (b == '0) begin
                        // zero divisor leaves the dividend in acc; rem restores its sign
                        hi_n      = rem;
                        lo_n      = '1;
                        divzero_n = 1'b1;
                    end else begin
                        hi_n      = rem;
                        lo_n      = quo;
                        divzero_n = 1'b0;
                    end
                end
            end
            default: st_n = IDLE;
        endcase

        busy_n = (st_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= IDLE;
            cnt     <= '0;
            op_r    <= 1'b0;
            nega    <= 1'b0;
            negb    <= 1'b0;
            acc     <= '0;
            q       <= '0;
            b       <= '0;
            hi      <= '0;
            lo      <= '0;
            prodv   <= 1'b0;
            divzero <= 1'b0;
            busy    <= 1'b0;
        end else begin
            st      <= st_n;
            cnt     <= cnt_n;
            op_r    <= op_n;
            nega    <= nega_n;
            negb    <= negb_n;
            acc     <= acc_n;
            q       <= q_n;
            b       <= b_n;
            hi      <= hi_n;
            lo      <= lo_n;
            prodv   <= prodv_n;
            divzero <= divzero_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: arithmetic reference model with cycle-countdown timing,
// per-cycle comparison, directed literal cases and randomized traffic.
module tb_mdu_iter;
    localparam int unsigned W = 32;

    logic         clk, reset, start, op, sgn, cancel, hiwe, lowe;
    logic [W-1:0] srca, srcb, wdata;
    logic         busy, prodv, divzero;
    logic [W-1:0] hi, lo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn),
        .srca(srca), .srcb(srcb), .cancel(cancel), .hiwe(hiwe), .lowe(lowe),
        .wdata(wdata), .busy(busy), .prodv(prodv), .divzero(divzero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // {divzero, hi, lo} from plain arithmetic
    function automatic logic [64:0] ref_op(input logic o, input logic s,
                                           input logic [W-1:0] a, input logic [W-1:0] bb);
        longint sa, sb, qq, rr, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(bb));
        if (!o) begin
            if (s) begin
                p = sa * sb;
                return {1'b0, 64'(p)};
            end
            up = 64'(a) * 64'(bb);
            return {1'b0, up};
        end
        if (bb == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (s) begin
            qq = sa / sb;
            rr = sa % sb;
            return {1'b0, 32'(rr), 32'(qq)};
        end
        return {1'b0, a % bb, a / bb};
    endfunction

    int           rem_cnt;
    logic         m_busy, m_prodv, m_dz;
    logic [W-1:0] m_hi, m_lo;
    logic [64:0]  pend;

    // reference: an operation occupies WIDTH+1 busy cycles, then a one-cycle result
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_cnt <= 0; m_busy <= 0; m_prodv <= 0; m_dz <= 0; m_hi <= 0; m_lo <= 0;
        end else begin
            m_prodv <= 1'b0;
            if (rem_cnt == 0) begin
                if (start && !cancel) begin
                    pend    <= ref_op(op, sgn, srca, srcb);
                    rem_cnt <= W + 1;
                    m_busy  <= 1'b1;
                end else begin
                    if (hiwe) m_hi <= wdata;
                    if (lowe) m_lo <= wdata;
                end
            end else if (cancel) begin
                rem_cnt <= 0;
                m_busy  <= 1'b0;
            end else if (rem_cnt == 1) begin
                rem_cnt <= 0;
                m_busy  <= 1'b0;
                m_prodv <= 1'b1;
                {m_dz, m_hi, m_lo} <= pend;
            end else begin
                rem_cnt <= rem_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("prodv", 64'(prodv), 64'(m_prodv));
            chk("divzero", 64'(divzero), 64'(m_dz));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic launch(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] bb);
        start = 1'b1; op = o; sgn = s; srca = a; srcb = bb;
    endtask

    task automatic wait_prodv(output int k);
        bit got;
        k = 0; got = 0;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            start = 1'b0; srca = $urandom; srcb = $urandom;
            if (prodv === 1'b1) got = 1;
        end
        chk("prodv_seen", 64'(got), 64'(1));
        chk("latency", 64'(k), 64'(34));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 8)
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int k;
        bit seen;
        reset = 1; start = 0; op = 0; sgn = 0; srca = 0; srcb = 0;
        cancel = 0; hiwe = 0; lowe = 0; wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_prodv", 64'(prodv), 0);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_dz", 64'(divzero), 0);
        reset = 0; chk_en = 1;
        @(negedge clk);

        launch(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_prodv(k);
        chk("umul_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        chk("umul_dz", 64'(divzero), 0);

        @(negedge clk);
        launch(0, 1, 32'hFFFF_FFFD, 32'd7);
        wait_prodv(k);
        chk("smul_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        launch(1, 1, 32'hFFFF_FFF9, 32'd2);
        wait_prodv(k);
        chk("sdiv_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        launch(1, 0, 32'd100, 32'd7);
        wait_prodv(k);
        chk("udiv_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
        launch(1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_prodv(k);
        chk("ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        chk("ovf_dz", 64'(divzero), 0);

        launch(1, 0, 32'h0000_1234, 32'd0);
        wait_prodv(k);
        chk("dz_flag", 64'(divzero), 1);
        chk("dz_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        launch(0, 0, 32'd3, 32'd4);
        wait_prodv(k);
        chk("dz_clear", 64'(divzero), 0);
        chk("mul34_hilo", {hi, lo}, 64'h0000_0000_0000_000C);

        @(negedge clk);
        hiwe = 1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        hiwe = 0; lowe = 1; wdata = 32'h0000_5555;
        @(negedge clk);
        lowe = 0;
        chk("preload", {hi, lo}, 64'h0000_AAAA_0000_5555);
        launch(0, 0, 32'd5, 32'd6);
        seen = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (prodv === 1'b1) seen = 1;
            if (c == 11) chk("cancel_busy", 64'(busy), 0);
            start  = (c == 5);
            srca   = 32'd9;
            hiwe   = (c == 7);
            wdata  = 32'h0;
            cancel = (c == 10);
        end
        chk("cancel_noprodv", 64'(seen), 0);
        chk("cancel_hilo", {hi, lo}, 64'h0000_AAAA_0000_5555);

        launch(1, 0, $urandom, 32'd3);
        repeat (20) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_hilo", {hi, lo}, 0);
        chk("arst_flags", {62'(0), prodv, divzero}, 0);
        @(negedge clk);
        reset = 0; start = 0;
        @(negedge clk);
        launch(0, 0, 32'd7, 32'd6);
        wait_prodv(k);
        chk("post_rst_hilo", {hi, lo}, 64'h0000_0000_0000_002A);

        repeat (6000) begin
            @(negedge clk);
            start  = ($urandom % 4 == 0);
            op     = 1'($urandom);
            sgn    = 1'($urandom);
            srca   = pick();
            srcb   = pick();
            cancel = ($urandom % 40 == 0);
            hiwe   = ($urandom % 10 == 0);
            lowe   = ($urandom % 10 == 0);
            wdata  = $urandom;
        end
        @(negedge clk);
        start = 0; cancel = 0; hiwe = 0; lowe = 0;
        repeat (40) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
